// File: rtl/pll_lock_sequencer.sv
// Power-up / relock sequencer for a single PLL primitive.
// Drives PLL_EN, waits for a synchronized LOCK with timeout, qualifies lock
// stability, retries a bounded number of times and reports READY / FAULT.
// Optional build macro: PLL_SEQ_GLITCH_FILTER_EN -- when defined, a lock drop
// in RUN must persist GLITCH_CYCLES consecutive cycles before it counts.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE   (0) | PLL disabled, waiting for START
// OFF    (1) | PLL_EN held low for OFF_CYCLES before an enable attempt
// WAIT_LOCK(2)| PLL_EN high, waiting up to LOCK_TIMEOUT for lock_s
// SETTLE (3) | lock_s must stay high SETTLE_CYCLES consecutive cycles
// RUN    (4) | PLL locked and qualified, READY high
// FAULT  (5) | retries exhausted, sticky until START drops or RESET
module pll_lock_sequencer #(
  parameter int OFF_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       LOCK,
  output logic       PLL_EN,
  output logic       READY,
  output logic       FAULT,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] LOCK_LOSS_CNT,
  output logic [2:0] STATE
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int CNT_W = $clog2(max4(OFF_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES, GLITCH_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] OFF_LOAD     = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
`ifdef PLL_SEQ_GLITCH_FILTER_EN
  localparam logic [CNT_W-1:0] GLITCH_LOAD  = CNT_W'(GLITCH_CYCLES - 1);
`endif
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_OFF       = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_SETTLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_en_q, pll_en_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             lock_meta_q, lock_s_q;
  logic             fail, lost;

  // Two-flop synchronizer for the asynchronous PLL LOCK output.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= LOCK;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Next-state, timer, retry/loss counters and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    fail    = 1'b0;
    lost    = 1'b0;

    if (!START) begin
      // Shutdown takes precedence over any lock event in the same cycle.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_OFF;
          retry_d = '0;
        end
        S_OFF: begin
          if (cnt_q == '0) state_d = S_WAIT_LOCK;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_WAIT_LOCK: begin
          if (lock_s_q)          state_d = S_SETTLE;
          else if (cnt_q == '0)  fail    = 1'b1;
          else                   cnt_d   = cnt_q - CNT_W'(1);
        end
        S_SETTLE: begin
          if (!lock_s_q)         fail    = 1'b1;
          else if (cnt_q == '0)  state_d = S_RUN;
          else                   cnt_d   = cnt_q - CNT_W'(1);
        end
        S_RUN: begin
`ifdef PLL_SEQ_GLITCH_FILTER_EN
          if (lock_s_q)          cnt_d = GLITCH_LOAD;
          else if (cnt_q == '0)  lost  = 1'b1;
          else                   cnt_d = cnt_q - CNT_W'(1);
`else
          if (!lock_s_q)         lost  = 1'b1;
`endif
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase

      if (fail) begin
        if (retry_q >= RETRY_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_OFF;
          retry_d = retry_q + 4'd1;
        end
      end

      if (lost) begin
        state_d = S_OFF;
        retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
      end

      if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;
    end

    // Every state entry reloads the shared timer for the new state.
    if (state_d != state_q) begin
      case (state_d)
        S_OFF:       cnt_d = OFF_LOAD;
        S_WAIT_LOCK: cnt_d = TIMEOUT_LOAD;
        S_SETTLE:    cnt_d = SETTLE_LOAD;
`ifdef PLL_SEQ_GLITCH_FILTER_EN
        S_RUN:       cnt_d = GLITCH_LOAD;
`endif
        default:     cnt_d = '0;
      endcase
    end

    pll_en_d = (state_d == S_WAIT_LOCK) || (state_d == S_SETTLE) || (state_d == S_RUN);
    ready_d  = (state_d == S_RUN);
    fault_d  = (state_d == S_FAULT);
  end

  // State, counter and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      loss_q   <= '0;
      pll_en_q <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      loss_q   <= loss_d;
      pll_en_q <= pll_en_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign PLL_EN        = pll_en_q;
  assign READY         = ready_q;
  assign FAULT         = fault_q;
  assign RETRY_CNT     = retry_q;
  assign LOCK_LOSS_CNT = loss_q;
  assign STATE         = state_q;

endmodule
